// File: rtl/irq_encoder_pkg.sv
// Shared types and sizing for the interrupt request encoder.
// Round-robin selection is enabled by defining IRQ_ENCODER_RR_EN.
package irq_encoder_pkg;

  localparam int DEF_WIDTH_OUT = 4;
  localparam int DEF_WIDTH_IN  = 2 ** DEF_WIDTH_OUT;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

endpackage

// File: rtl/irq_encoder_prio_find.sv
// Combinational find-first-set starting at a rotation base, wrapping modulo WIDTH_IN.
module prio_find #(
  parameter int WIDTH_OUT = 4,
  parameter int WIDTH_IN  = 2 ** WIDTH_OUT
) (
  input  logic [WIDTH_IN-1:0]  vec_i,
  input  logic [WIDTH_OUT-1:0] base_i,
  output logic [WIDTH_OUT-1:0] idx_o,
  output logic                 found_o
);

  logic [WIDTH_OUT-1:0] pos;

  // Scan from the farthest offset down so the hit nearest to base_i is assigned last.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    pos     = '0;
    for (int i = WIDTH_IN - 1; i >= 0; i--) begin
      pos = base_i + WIDTH_OUT'(i);
      if (vec_i[pos]) begin
        idx_o   = pos;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_encoder.sv
// Latches request strobes, picks one eligible source and holds its index until acked.
// Define IRQ_ENCODER_RR_EN for round-robin priority; otherwise lowest index wins.
module irq_encoder
  import irq_encoder_pkg::*;
#(
  parameter int WIDTH_OUT = DEF_WIDTH_OUT,
  parameter int WIDTH_IN  = 2 ** WIDTH_OUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH_IN-1:0]  req,
  input  logic [WIDTH_IN-1:0]  mask,
  input  logic                 ack,
  output logic                 valid,
  output logic [WIDTH_OUT-1:0] idx,
  output logic [WIDTH_IN-1:0]  pending,
  output state_e               state_o
);

  // Handshake: idx is meaningful while valid=1 and stays frozen until the cycle
  // in which ack=1 is sampled; ack while valid=0 is ignored.

  state_e               state_q;
  logic                 valid_q;
  logic [WIDTH_OUT-1:0] idx_q;
  logic [WIDTH_IN-1:0]  pending_q;
  logic [WIDTH_IN-1:0]  pending_d;
  logic [WIDTH_IN-1:0]  elig;
  logic [WIDTH_IN-1:0]  clr;
  logic [WIDTH_OUT-1:0] base;
  logic [WIDTH_OUT-1:0] sel_idx;
  logic                 sel_found;
  logic                 grant_done;

  assign grant_done = ack && (state_q == PRESENT);
  assign clr        = grant_done ? (WIDTH_IN'(1) << idx_q) : '0;
  // A request arriving on the ack edge re-sets the bit being cleared.
  assign pending_d  = (pending_q & ~clr) | req;
  assign elig       = pending_q & mask;

`ifdef IRQ_ENCODER_RR_EN
  logic [WIDTH_OUT-1:0] ptr_q;

  assign base = ptr_q + WIDTH_OUT'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= WIDTH_OUT'(WIDTH_IN - 1);
    end else if (grant_done) begin
      ptr_q <= idx_q;
    end
  end
`else
  assign base = '0;
`endif

  prio_find #(
    .WIDTH_OUT (WIDTH_OUT),
    .WIDTH_IN  (WIDTH_IN)
  ) u_prio_find (
    .vec_i   (elig),
    .base_i  (base),
    .idx_o   (sel_idx),
    .found_o (sel_found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
      case (state_q)
        IDLE: begin
          if (sel_found) begin
            idx_q   <= sel_idx;
            valid_q <= 1'b1;
            state_q <= PRESENT;
          end
        end
        PRESENT: begin
          if (ack) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign valid   = valid_q;
  assign idx     = idx_q;
  assign pending = pending_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_irq_encoder.sv
// Directed bench for irq_encoder: reset, single sweep, multi-hot, masking,
// set-over-clear and reset mid-operation.
module tb_irq_encoder;
  import irq_encoder_pkg::*;

  localparam int WO = 4;
  localparam int WI = 16;

  logic          clk;
  logic          rst;
  logic [WI-1:0] req;
  logic [WI-1:0] mask;
  logic          ack;
  logic          valid;
  logic [WO-1:0] idx;
  logic [WI-1:0] pending;
  state_e        state_o;

  int checks   = 0;
  int failures = 0;
  logic [WO-1:0] exp_q[$];

  irq_encoder #(.WIDTH_OUT(WO)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .mask    (mask),
    .ack     (ack),
    .valid   (valid),
    .idx     (idx),
    .pending (pending),
    .state_o (state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: inputs change 1 time unit after the edge, outputs sampled there too
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: expected granted index is queued when stimulus is sent
  task automatic chk_grant(input string tag);
    logic [WO-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_valid"}, 32'(valid), 32'd1);
      chk({tag, "_idx"}, 32'(idx), 32'(e));
    end
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    req  = '0;
    mask = 16'hFFFF;
    ack  = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // reset then idle
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle_valid", 32'(valid), 32'd0);
      chk("idle_idx", 32'(idx), 32'd0);
      chk("idle_pending", 32'(pending), 32'd0);
    end

    // single-bit sweep
    for (int k = 0; k < WI; k++) begin
      exp_q.push_back(WO'(k));
      req = 16'(1) << k;
      tick();
      chk("sweep_pend_set", 32'(pending), 32'(16'(1) << k));
      chk("sweep_not_yet", 32'(valid), 32'd0);
      req = '0;
      tick();
      chk_grant("sweep");
      do_ack();
      chk("sweep_ack_valid", 32'(valid), 32'd0);
      chk("sweep_ack_pend", 32'(pending), 32'd0);
    end

    // multi-hot, no preemption
    exp_q.push_back(4'd5);
    req = 16'h00A0;
    tick();
    req = '0;
    tick();
    chk_grant("multi_first");
    req = 16'h0001;
    tick();
    req = '0;
    chk("nopre_idx", 32'(idx), 32'd5);
    chk("nopre_pend", 32'(pending), 32'h00A1);
    tick();
    chk("nopre_idx2", 32'(idx), 32'd5);
    do_ack();
    chk("multi_ack_valid", 32'(valid), 32'd0);
    chk("multi_ack_pend", 32'(pending), 32'h0081);
`ifdef IRQ_ENCODER_RR_EN
    exp_q.push_back(4'd7);
    exp_q.push_back(4'd0);
`else
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd7);
`endif
    tick();
    chk_grant("multi_second");
    do_ack();
    tick();
    chk_grant("multi_third");
    do_ack();
    chk("multi_drained", 32'(pending), 32'd0);

    // masking
    mask = 16'h8000;
    req  = 16'h8001;
    exp_q.push_back(4'd15);
    tick();
    req = '0;
    tick();
    chk_grant("mask");
    chk("mask_pend", 32'(pending), 32'h8001);
    do_ack();
    chk("mask_ack_valid", 32'(valid), 32'd0);
    chk("mask_ack_pend", 32'(pending), 32'h0001);
    ack = 1'b1;  // ack while idle must not clear anything
    tick();
    ack = 1'b0;
    chk("idle_ack_valid", 32'(valid), 32'd0);
    chk("idle_ack_pend", 32'(pending), 32'h0001);
    mask = 16'hFFFF;
    exp_q.push_back(4'd0);
    tick();
    chk_grant("unmask");
    do_ack();
    chk("unmask_pend", 32'(pending), 32'd0);

    // set wins over clear
    exp_q.push_back(4'd3);
    req = 16'h0008;
    tick();
    req = '0;
    tick();
    chk_grant("setclr_first");
    ack = 1'b1;
    req = 16'h0008;
    tick();
    ack = 1'b0;
    req = '0;
    chk("setclr_valid_drop", 32'(valid), 32'd0);
    chk("setclr_pend", 32'(pending), 32'h0008);
    exp_q.push_back(4'd3);
    tick();
    chk_grant("setclr_again");
    do_ack();
    chk("setclr_drained", 32'(pending), 32'd0);

    // reset mid-operation
    req = 16'hFFFF;
    tick();
    req = '0;
`ifdef IRQ_ENCODER_RR_EN
    exp_q.push_back(4'd4);
`else
    exp_q.push_back(4'd0);
`endif
    tick();
    chk_grant("pre_reset");
    chk("pre_reset_pend", 32'(pending), 32'hFFFF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_pend", 32'(pending), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_idx", 32'(idx), 32'd0);
    tick();
    chk("rst_stay_idle", 32'(valid), 32'd0);
    req = 16'hFFFF;
    exp_q.push_back(4'd0);
    tick();
    req = '0;
    tick();
    chk_grant("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
